// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_DIVU = 2'b10,
    OP_REM  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } muldiv_state_t;

  function automatic logic opIsSigned(input muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: MSB-first shift-add for MUL, restoring
// divide step (WIDTH+1-bit trial remainder) for the divide ops.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  muldiv_op_t       op_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH:0] trial;
  logic           fits;

  // opa_i MSB is the next dividend bit; opb_i MSB is the next multiplier bit.
  always_comb begin
    trial = {rem_i, opa_i[WIDTH-1]};
    fits  = (trial >= {1'b0, opb_i});
    acc_o = acc_i;
    rem_o = rem_i;
    if (op_i == OP_MUL) begin
      acc_o = {acc_i[WIDTH-2:0], 1'b0} + (opb_i[WIDTH-1] ? opa_i : '0);
    end else if (fits) begin
      rem_o = WIDTH'(trial - {1'b0, opb_i});
      acc_o = {acc_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = trial[WIDTH-1:0];
      acc_o = {acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MUL/DIV/DIVU/REM sequencer with core stall output.
// Optional MULDIV_SEQ_FAST_ZERO_EN skips CALC when either operand is zero.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  muldiv_op_t       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  muldiv_state_t    state_q;
  muldiv_op_t       op_q;
  logic [WIDTH-1:0] opA_q, opB_q, acc_q, rem_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             negA_q, negQ_q, dz_q;

  logic             accept, aNeg, bNeg, fastSkip;
  logic [WIDTH-1:0] aAbs, bAbs, accD, remD;
  logic [WIDTH-1:0] quotient, remainder, fixResult;

  assign accept = start_i & ((state_q == ST_IDLE) || (state_q == ST_DONE)) & ~flush_i;
  assign aNeg   = opIsSigned(op_i) & a_i[WIDTH-1];
  assign bNeg   = opIsSigned(op_i) & b_i[WIDTH-1];
  assign aAbs   = aNeg ? -a_i : a_i;
  assign bAbs   = bNeg ? -b_i : b_i;

`ifdef MULDIV_SEQ_FAST_ZERO_EN
  assign fastSkip = (a_i == '0) || (b_i == '0);
`else
  assign fastSkip = 1'b0;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_i  (op_q),
    .acc_i (acc_q),
    .rem_i (rem_q),
    .opa_i (opA_q),
    .opb_i (opB_q),
    .acc_o (accD),
    .rem_o (remD)
  );

  always_comb begin
    quotient  = negQ_q ? -acc_q : acc_q;
    remainder = negA_q ? -rem_q : rem_q;
    case (op_q)
      OP_MUL:          fixResult = acc_q;
      OP_DIV, OP_DIVU: fixResult = dz_q ? '1 : quotient;
      default:         fixResult = remainder;
    endcase
  end

  // A skipped divide-by-zero never shifts the dividend in, so preload |a| as the remainder.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      opA_q    <= '0;
      opB_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      negA_q   <= 1'b0;
      negQ_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            op_q    <= op_i;
            opA_q   <= aAbs;
            opB_q   <= bAbs;
            negA_q  <= aNeg;
            negQ_q  <= aNeg ^ bNeg;
            dz_q    <= (b_i == '0);
            acc_q   <= '0;
            rem_q   <= (fastSkip && (b_i == '0)) ? aAbs : '0;
            cnt_q   <= '0;
            state_q <= fastSkip ? ST_FIX : ST_CALC;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CALC: begin
          acc_q <= accD;
          rem_q <= remD;
          if (op_q == OP_MUL) opB_q <= opB_q << 1;
          else                opA_q <= opA_q << 1;
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            state_q <= ST_FIX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_FIX: begin
          result_q <= fixResult;
          state_q  <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done_o   = (state_q == ST_DONE);
  assign stall_o  = busy_o | accept;
  assign result_o = result_q;

endmodule
